// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its surroundings.
//
// Purpose: groups the core load/store handshake, the external
// (loader/debug) port and the single-port memory strobes.
//
// Port summary:
//   core_*  : core request/response (core_req held until core_done)
//   ext_*   : external valid/ready access port plus read return
//   mem_*   : single-port memory strobes, address, data
//
// Modports:
//   slave  : the arbiter's view (serves the requesters, drives the memory)
//   master : the environment's view (requesters and memory)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_done;
    logic              core_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_done, core_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_done, core_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Multi-cycle arbiter/sequencer for the single-port data memory.
//
// Purpose: shares one memory port between the core load/store path and
// an external loader/debug port. Round-robin between the two, with the
// external side limited to MAX_BURST consecutive accesses while the core
// is waiting. The core is stalled (core_stall) while its access is open.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   bus       : dmem_arbiter_if.slave (core, external and memory signals)
//   dbg_state : current FSM state (IDLE=0, CORE_ACC=1, CORE_RD=2, EXT=3)
//
// Handshakes:
//   core : core_req/we/addr/wdata are held stable until the one-cycle
//          core_done pulse; core_req seen during core_done is the request
//          just served, never a new one.
//   ext  : valid/ready -- an access transfers in every cycle with
//          ext_req & ext_gnt; read data returns two cycles later on the
//          one-cycle ext_rvalid pulse.
//   mem  : exactly one strobe per cycle at most; mem_rdata is valid the
//          cycle after mem_read.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_ACC = 2'd1,
        CORE_RD  = 2'd2,
        EXT      = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_t;

    state_t            state, state_nxt;
    owner_t            last_owner, last_owner_nxt;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
    logic              rd_pend;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              core_new;
    logic              burst_full;
    logic              ext_acc;

    assign dbg_state      = state;
    assign bus.core_stall = bus.core_req & ~bus.core_done;

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        bus.ext_gnt    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        ext_acc        = 1'b0;
        // A request still high in its done cycle is the one just served.
        core_new       = bus.core_req & ~bus.core_done;
        burst_full     = (burst_cnt == CNT_W'(MAX_BURST));

        case (state)
            IDLE: begin
                if (core_new && (!bus.ext_req || last_owner == OWN_EXT)) begin
                    state_nxt = CORE_ACC;
                end else if (bus.ext_req) begin
                    state_nxt = EXT;
                end
            end
            CORE_ACC: begin
                bus.mem_read   = ~bus.core_we;
                bus.mem_write  = bus.core_we;
                bus.mem_addr   = bus.core_addr;
                bus.mem_wdata  = bus.core_wdata;
                last_owner_nxt = OWN_CORE;
                state_nxt      = bus.core_we ? IDLE : CORE_RD;
            end
            CORE_RD: begin
                state_nxt = IDLE;
            end
            EXT: begin
                last_owner_nxt = OWN_EXT;
                // Ready drops only when the burst budget is spent and the
                // core is waiting; the hand-over is decided in that cycle.
                bus.ext_gnt = ~(burst_full & bus.core_req);
                if (bus.ext_gnt && bus.ext_req) begin
                    ext_acc       = 1'b1;
                    bus.mem_read  = ~bus.ext_we;
                    bus.mem_write = bus.ext_we;
                    bus.mem_addr  = bus.ext_addr;
                    bus.mem_wdata = bus.ext_wdata;
                    if (!burst_full) begin
                        burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    end
                end else if (bus.core_req) begin
                    state_nxt     = CORE_ACC;
                    burst_cnt_nxt = '0;
                end else if (!bus.ext_req) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_owner     <= OWN_EXT;
            burst_cnt      <= '0;
            rd_pend        <= 1'b0;
            bus.core_done  <= 1'b0;
            bus.core_rdata <= '0;
            bus.ext_rvalid <= 1'b0;
            bus.ext_rdata  <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            state          <= state_nxt;
            last_owner     <= last_owner_nxt;
            burst_cnt      <= burst_cnt_nxt;
            bus.core_done  <= (state == CORE_ACC && bus.core_we) || (state == CORE_RD);
            if (state == CORE_RD) begin
                bus.core_rdata <= bus.mem_rdata;
            end
            // External read return runs regardless of the current state.
            rd_pend        <= ext_acc & ~bus.ext_we;
            bus.ext_rvalid <= rd_pend;
            if (rd_pend) begin
                bus.ext_rdata <= bus.mem_rdata;
            end
            // mem_addr/mem_wdata equal these when no strobe is active.
            addr_q         <= bus.mem_addr;
            wdata_q        <= bus.mem_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc_no = 0;
    always @(posedge clock) cyc_no <= cyc_no + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [15:0] mem_arr [256];
    logic [15:0] ref_mem [256];

    always @(posedge clock) begin
        if (bus.mem_write) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= mem_arr[bus.mem_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] ext_exp_q[$];
    int rv_log[$];
    int acc_log[$];
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset && bus.core_done) done_cnt++;
        if (reset && bus.ext_rvalid) begin
            rv_log.push_back(cyc_no);
            chk("ext_rvalid_expected", 32'(ext_exp_q.size() != 0), 32'd1);
            if (ext_exp_q.size() != 0) chk("ext_rdata", 32'(bus.ext_rdata), 32'(ext_exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Core access: hold the request until core_done, then drop it.
    task automatic core_access(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                               input int max_cyc, output int done_cyc);
        int cyc = 0;
        logic [15:0] exp = ref_mem[addr];
        done_cyc = -1;
        bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
        while (cyc < max_cyc) begin
            @(negedge clock);
            if (bus.core_done) begin
                done_cyc = cyc_no;
                break;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("core_done_seen", 32'(done_cyc >= 0), 32'd1);
        if (done_cyc >= 0 && !we) chk("core_load_rdata", 32'(bus.core_rdata), 32'(exp));
        if (we) ref_mem[addr] = wdata;
        @(posedge clock);
        #1;
        bus.core_req = 1'b0;
    endtask

    // External burst of n accesses from base; advances only on ext_gnt.
    task automatic ext_run(input int n, input logic we, input logic [7:0] base, input int max_cyc);
        int i = 0;
        int cyc = 0;
        logic [15:0] d = 16'($urandom_range(0, 16'hFFFF));
        while (i < n && cyc < max_cyc) begin
            bus.ext_req = 1'b1; bus.ext_we = we; bus.ext_addr = base + 8'(i); bus.ext_wdata = d;
            @(negedge clock);
            if (bus.ext_gnt) begin
                acc_log.push_back(cyc_no);
                if (we) ref_mem[bus.ext_addr] = d;
                else    ext_exp_q.push_back(ref_mem[bus.ext_addr]);
                i++;
                d = 16'($urandom_range(0, 16'hFFFF));
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        bus.ext_req = 1'b0;
        chk("ext_run_accepted", 32'(i), 32'(n));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        logic        creq, cwe;
        logic [7:0]  caddr;
        logic [15:0] cwd;
        logic        ereq, ewe;
        logic [7:0]  eaddr;
        logic [15:0] ewd;
        logic        x_gnt, x_rd, x_wr;
        logic [7:0]  x_addr;
        logic [15:0] x_wd;
        logic        x_done, x_stall;
        logic [1:0]  x_state;
        bit          chk_rd;
        logic [15:0] x_rdata;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int t0;
        int dc;
        int ds;
        int exp_g[6];

        for (int a = 0; a < 256; a++) begin
            mem_arr[a] = 16'h0;
            ref_mem[a] = 16'h0;
        end
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 8'h0; bus.core_wdata = 16'h0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 8'h0; bus.ext_wdata = 16'h0;
        bus.mem_rdata = 16'h0;
        reset = 1'b1;
        #2;
        apply_reset();

        // Reset values
        @(negedge clock);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_core_done", 32'(bus.core_done), 32'd0);
        chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
        chk("rst_ext_gnt", 32'(bus.ext_gnt), 32'd0);
        chk("rst_mem_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("rst_core_rdata", 32'(bus.core_rdata), 32'd0);
        chk("rst_ext_rdata", 32'(bus.ext_rdata), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);

        //             rst   creq  cwe   caddr  cwd         ereq  ewe   eaddr  ewd         gnt   rd    wr    addr   wd          done  stall state  chk   rdata
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'hBEEF, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'hBEEF, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 16'hBEEF};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1234, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h20, 16'h1234, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 8'h30, 16'h5555, 1'b1, 1'b0, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h30, 16'h5555, 1'b1, 1'b0, 1'b0, 8'h30, 16'h5555, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h30, 16'h5555, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000};

        for (int r = 0; r < 13; r++) begin
            if (vecs[r].rst) apply_reset();
            else begin
                @(posedge clock);
                #1;
            end
            bus.core_req = vecs[r].creq; bus.core_we = vecs[r].cwe;
            bus.core_addr = vecs[r].caddr; bus.core_wdata = vecs[r].cwd;
            bus.ext_req = vecs[r].ereq; bus.ext_we = vecs[r].ewe;
            bus.ext_addr = vecs[r].eaddr; bus.ext_wdata = vecs[r].ewd;
            @(negedge clock);
            chk($sformatf("v%0d_ext_gnt", r), 32'(bus.ext_gnt), 32'(vecs[r].x_gnt));
            chk($sformatf("v%0d_mem_read", r), 32'(bus.mem_read), 32'(vecs[r].x_rd));
            chk($sformatf("v%0d_mem_write", r), 32'(bus.mem_write), 32'(vecs[r].x_wr));
            chk($sformatf("v%0d_mem_addr", r), 32'(bus.mem_addr), 32'(vecs[r].x_addr));
            chk($sformatf("v%0d_mem_wdata", r), 32'(bus.mem_wdata), 32'(vecs[r].x_wd));
            chk($sformatf("v%0d_core_done", r), 32'(bus.core_done), 32'(vecs[r].x_done));
            chk($sformatf("v%0d_core_stall", r), 32'(bus.core_stall), 32'(vecs[r].x_stall));
            chk($sformatf("v%0d_state", r), 32'(dbg_state), 32'(vecs[r].x_state));
            if (vecs[r].chk_rd) chk($sformatf("v%0d_core_rdata", r), 32'(bus.core_rdata), 32'(vecs[r].x_rdata));
        end
        ref_mem[8'h10] = 16'hBEEF;
        ref_mem[8'h20] = 16'h1234;
        ref_mem[8'h30] = 16'h5555;
        @(posedge clock);
        #1;
        idle(2);

        // Six back-to-back external writes, core idle
        acc_log.delete();
        t0 = cyc_no;
        ext_run(6, 1'b1, 8'h00, 20);
        chk("wr_burst_first_gnt", 32'(acc_log[0] - t0), 32'd1);
        chk("wr_burst_consecutive", 32'(acc_log[acc_log.size()-1] - acc_log[0]), 32'd5);
        idle(3);

        // Read-back: six rvalid pulses on consecutive cycles
        acc_log.delete();
        rv_log.delete();
        t0 = cyc_no;
        ext_run(6, 1'b0, 8'h00, 20);
        idle(4);
        chk("rd_burst_rvalid_count", 32'(rv_log.size()), 32'd6);
        if (rv_log.size() == 6) begin
            chk("rd_burst_first_rvalid", 32'(rv_log[0] - t0), 32'd3);
            chk("rd_burst_rvalid_consecutive", 32'(rv_log[5] - rv_log[0]), 32'd5);
        end

        // Core store so the core is the last owner, then bounded ext burst
        core_access(1'b1, 8'h11, 16'hA5A5, 20, dc);
        acc_log.delete();
        t0 = cyc_no;
        exp_g = '{1, 2, 3, 4, 9, 10};
        fork
            ext_run(6, 1'b0, 8'h00, 40);
            core_access(1'b0, 8'h10, 16'h0000, 40, dc);
        join
        chk("burst_accept_count", 32'(acc_log.size()), 32'd6);
        if (acc_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("burst_gnt_cycle%0d", k), 32'(acc_log[k] - t0), 32'(exp_g[k]));
        end
        chk("burst_core_done_cycle", 32'(dc - t0), 32'd8);
        idle(4);

        // Reset while the core load sits in CORE_RD
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10; bus.core_wdata = 16'h0;
        idle(2);
        @(negedge clock);
        chk("rdrst_in_core_rd", 32'(dbg_state), 32'd2);
        ds = done_cnt;
        reset = 1'b0;
        #1;
        chk("rdrst_state_async", 32'(dbg_state), 32'd0);
        chk("rdrst_core_rdata", 32'(bus.core_rdata), 32'd0);
        bus.core_req = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(4);
        chk("rdrst_no_done", 32'(done_cnt), 32'(ds));
        chk("rdrst_state_after", 32'(dbg_state), 32'd0);
        chk("rdrst_core_rdata_after", 32'(bus.core_rdata), 32'd0);

        // Ext read in its last EXT access, core store to the same word follows
        acc_log.delete();
        rv_log.delete();
        fork
            ext_run(1, 1'b0, 8'h02, 20);
            begin
                @(posedge clock);
                #1;
                core_access(1'b1, 8'h02, 16'hC0DE, 20, dc);
            end
        join
        idle(3);
        chk("ovl_rvalid_count", 32'(rv_log.size()), 32'd1);
        if (rv_log.size() == 1 && acc_log.size() == 1) begin
            chk("ovl_rvalid_latency", 32'(rv_log[0] - acc_log[0]), 32'd2);
            chk("ovl_store_same_cycle", 32'(dc - 1), 32'(rv_log[0]));
        end
        core_access(1'b0, 8'h02, 16'h0000, 20, dc);
        idle(3);

        chk("ext_exp_q_drained", 32'(ext_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Multi-cycle arbiter/sequencer for the single-port data memory (8-bit address, 16-bit word).
- Shares the memory between two requesters:
  - the core load/store path;
  - an external port used for program/data loading and debug.
- Stalls the core through pc_write while its access is pending.
- Round-robin between requesters, with a bounded external burst length.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width
MAX_BURST, 4, maximum consecutive external accesses while core_req is pending (≥1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core memory request; core holds req/we/addr/wdata stable until core_done
core_we  in  1  1=store, 0=load
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  store data
core_rdata  out  DATA_W  load data, registered, valid while core_done=1, held afterwards
core_done  out  1  one-cycle completion pulse, registered
core_stall  out  1  core_req & ~core_done, combinational; top level drives pc_write = ~core_stall
ext_req  in  1  external access request (valid)
ext_we  in  1  external write enable
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  external ready; access accepted on ext_req & ext_gnt
ext_rvalid  out  1  one-cycle pulse, registered; ext_rdata valid
ext_rdata  out  DATA_W  external read data, registered, held
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read

Behaviour:
- States:
  - IDLE: no memory strobes.
  - CORE_ACC: issue core access; mem_* driven from core_*.
  - CORE_RD: capture mem_rdata into core_rdata at end of cycle.
  - EXT: ext_gnt=1; mem_* driven from ext_*, gated by ext_req.
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=EXT, burst_cnt=0, rd_pend=0;
  - core_done, ext_rvalid, ext_gnt, mem_read, mem_write all 0;
  - core_rdata, ext_rdata, mem_addr, mem_wdata all 0.
  - Pending reads are dropped: no done or rvalid pulse after reset.
- IDLE:
  - Only core_req (not in its done cycle): go to CORE_ACC.
  - Only ext_req: go to EXT.
  - Both: grant the requester not equal to last_owner.
  - Arbitration costs one cycle.
- CORE_ACC (issue cycle G):
  - Store: mem_write=1; core_done=1 in G+1; next state IDLE.
  - Load: mem_read=1; next state CORE_RD; core_rdata=mem_rdata at end of G+1; core_done=1 in G+2; then IDLE.
  - last_owner=CORE.
- Core latency from request in IDLE: store completes in 2 cycles, load in 3 cycles.
- core_req seen in the cycle where core_done=1 is the served request, not a new one.
- EXT:
  - Each cycle with ext_req=1 issues one access and increments burst_cnt (saturates at MAX_BURST).
  - Leave to CORE_ACC, clearing burst_cnt, when either:
    - ext_req=0 and core_req=1, or
    - burst_cnt==MAX_BURST and core_req=1; ext_gnt is 0 in the cycle of that decision.
  - Leave to IDLE when ext_req=0 and core_req=0.
  - Back-to-back external accesses at one per cycle are allowed.
  - Unbounded burst while core_req=0.
  - last_owner=EXT.
- External read pipeline (independent of state): read accepted in G → rd_pend=1 → ext_rdata=mem_rdata at end of G+1 → ext_rvalid=1 in G+2. Delivered even if the state left EXT.
- Exactly one memory access per cycle. mem_read and mem_write are never both 1.
- mem_addr/mem_wdata hold their last value when no strobe is active.

Test Plan:
- Reset, store then load, no ext traffic:
  - core store 0x10=0xBEEF: mem_write in cycle 1, core_done in cycle 2, stall in cycles 0–1.
  - core load 0x10: mem_read issued, core_rdata=0xBEEF with core_done 2 cycles after issue.
- Right after reset, core_req and ext_req rise together: core is granted first (last_owner=EXT); ext_gnt rises after core_done.
- MAX_BURST=4, ext issues 6 reads to 0x00–0x05 with core load pending: exactly 4 accepted, then ext_gnt=0, core served, then ext resumes with 0x04. ext_rvalid data matches memory contents.
- 6 back-to-back ext writes with core idle: all accepted consecutively, no ext_gnt drop. Read-back shows 6 ext_rvalid pulses on consecutive cycles.
- reset→0 during CORE_RD: no core_done pulse; core_rdata=0; state IDLE after release.
- Ext read issued in the final EXT cycle, then core store granted: ext_rvalid still pulses 2 cycles after issue with correct data, overlapping the core access without corruption.
